// File: rtl/xcvr_csr_agent_pkg.sv
// xcvr_csr_agent_pkg: response codes, error read data and sizing helper shared by the
// CSR agent top and its response pipe.
package xcvr_csr_agent_pkg;

   // Avalon-MM response code
   typedef logic [1:0] resp_t;

   localparam resp_t       RESP_OKAY   = 2'b00;
   localparam resp_t       RESP_DECERR = 2'b11;

   // Returned for reads that hit no implemented register
   localparam logic [31:0] DECERR_DATA = 32'hDEAD_C0DE;

   // Index width for a register bank; a single-register bank still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xcvr_csr_resp_pipe.sv
// xcvr_csr_resp_pipe: fixed-latency response pipe plus outstanding-response counter.
// An entry pushed at an edge appears at the outputs READ_LATENCY cycles later.
// Optional feature macro: XCVR_CSR_AGENT_WRRESP_EN -- write responses share the pipe and the
// counter, and every entry carries a response code.
module xcvr_csr_resp_pipe
   import xcvr_csr_agent_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_PENDING  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push_rd,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
`ifdef XCVR_CSR_AGENT_WRRESP_EN
   input  logic                  i_push_wr,
   input  logic [1:0]            i_resp,
   output logic                  o_wr_valid,
   output logic [1:0]            o_resp,
`endif
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_full
);

   localparam int unsigned CntW = $clog2(MAX_PENDING + 1);

   logic [READ_LATENCY-1:0] r_rd_vld;
   logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];
   logic [CntW-1:0]         r_pending;
   logic                    w_push;
   logic                    w_pop;

`ifdef XCVR_CSR_AGENT_WRRESP_EN
   logic [READ_LATENCY-1:0] r_wr_vld;
   resp_t                   r_resp [READ_LATENCY];

   assign w_push     = i_push_rd | i_push_wr;
   assign w_pop      = r_rd_vld[READ_LATENCY-1] | r_wr_vld[READ_LATENCY-1];
   assign o_wr_valid = r_wr_vld[READ_LATENCY-1];
   assign o_resp     = r_resp[READ_LATENCY-1];

   // Write-valid shift and response code; the code moves with any entry so it holds afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_resp[i] <= RESP_OKAY;
         end
      end else begin
         r_wr_vld[0] <= i_push_wr;
         if (i_push_rd || i_push_wr) begin
            r_resp[0] <= i_resp;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_wr_vld[i] <= r_wr_vld[i-1];
            if (r_rd_vld[i-1] || r_wr_vld[i-1]) begin
               r_resp[i] <= r_resp[i-1];
            end
         end
      end
   end
`else
   assign w_push = i_push_rd;
   assign w_pop  = r_rd_vld[READ_LATENCY-1];
`endif

   // Read-valid shifts every cycle; data only moves with a valid read so the last stage holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_rd_vld[0] <= i_push_rd;
         if (i_push_rd) begin
            r_data[0] <= i_rd_data;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_rd_vld[i] <= r_rd_vld[i-1];
            if (r_rd_vld[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   // Outstanding responses: push and pop in the same cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else if (w_push && !w_pop) begin
         r_pending <= r_pending + 1'b1;
      end else if (w_pop && !w_push) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   assign o_rd_valid = r_rd_vld[READ_LATENCY-1];
   assign o_rd_data  = r_data[READ_LATENCY-1];
   assign o_full     = (r_pending == CntW'(MAX_PENDING));

endmodule

// File: rtl/xcvr_csr_agent.sv
// xcvr_csr_agent: Avalon-MM responder holding a bank of RW control / RO status registers
// behind the transceiver MM bridge. Reads return after a fixed latency via xcvr_csr_resp_pipe.
// Optional feature macro: XCVR_CSR_AGENT_WRRESP_EN -- adds s_response and
// s_writeresponsevalid; writes then occupy the response pipe like reads.
module xcvr_csr_agent
   import xcvr_csr_agent_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter int unsigned          ADDR_WIDTH   = 13,
   parameter int unsigned          NUM_REGS     = 16,
   parameter logic [NUM_REGS-1:0]  RO_MASK      = '0,
   parameter int unsigned          READ_LATENCY = 2,
   parameter int unsigned          MAX_PENDING  = 2
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [ADDR_WIDTH-1:0]          s_address,
   input  logic                           s_read,
   input  logic                           s_write,
   input  logic [DATA_WIDTH-1:0]          s_writedata,
   input  logic [DATA_WIDTH/8-1:0]        s_byteenable,
   output logic                           s_waitrequest,
   output logic [DATA_WIDTH-1:0]          s_readdata,
   output logic                           s_readdatavalid,
`ifdef XCVR_CSR_AGENT_WRRESP_EN
   output logic [1:0]                     s_response,
   output logic                           s_writeresponsevalid,
`endif
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctl_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] sts_in
);

   localparam int unsigned           NumBytes   = DATA_WIDTH / 8;
   localparam int unsigned           IdxW       = idx_width(NUM_REGS);
   localparam logic [ADDR_WIDTH:0]   NumRegsA   = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [DATA_WIDTH-1:0] DecerrData = DATA_WIDTH'(DECERR_DATA);

   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_ctl [NUM_REGS];
   logic                  w_full;
   logic                  w_accept_wr;
   logic                  w_accept_rd;
   logic                  w_in_range;
   logic                  w_is_ro;
   logic                  w_wr_hit;
   logic [IdxW-1:0]       w_idx;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Keep commands stalled through the first edge after reset release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
      end
   end

   assign s_waitrequest = !r_ready || w_full;

   // A simultaneous read and write is taken as a write only; the read gets no response
   assign w_accept_wr = s_write && !s_waitrequest;
   assign w_accept_rd = s_read && !s_write && !s_waitrequest;

   assign w_in_range = ({1'b0, s_address} < NumRegsA);
   assign w_idx      = s_address[IdxW-1:0];
   assign w_is_ro    = w_in_range && RO_MASK[w_idx];
   assign w_wr_hit   = w_accept_wr && w_in_range;

   // Byte-lane writes into RW registers; RO registers never take write data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_ctl[i] <= '0;
         end
      end else if (w_wr_hit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IdxW'(i) && !RO_MASK[i]) begin
               for (int b = 0; b < NumBytes; b++) begin
                  if (s_byteenable[b]) begin
                     r_ctl[i][b*8 +: 8] <= s_writedata[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read source: status input for RO registers, control value for RW, error pattern otherwise
   always_comb begin
      w_rd_data = DecerrData;
      if (w_in_range) begin
         if (w_is_ro) begin
            w_rd_data = sts_in[w_idx*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            w_rd_data = r_ctl[w_idx];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctl_out
      assign ctl_out[g*DATA_WIDTH +: DATA_WIDTH] = r_ctl[g];
   end

`ifdef XCVR_CSR_AGENT_WRRESP_EN
   resp_t w_resp;

   // Decode error for unmapped addresses and for writes aimed at a read-only register
   always_comb begin
      w_resp = RESP_OKAY;
      if (!w_in_range || (s_write && w_is_ro)) begin
         w_resp = RESP_DECERR;
      end
   end
`endif

   xcvr_csr_resp_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .MAX_PENDING  (MAX_PENDING)
   ) u_resp_pipe (
      .clk        (clk),
      .rst_n      (reset_n),
      .i_push_rd  (w_accept_rd),
      .i_rd_data  (w_rd_data),
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      .i_push_wr  (w_accept_wr),
      .i_resp     (w_resp),
      .o_wr_valid (s_writeresponsevalid),
      .o_resp     (s_response),
`endif
      .o_rd_valid (s_readdatavalid),
      .o_rd_data  (s_readdata),
      .o_full     (w_full)
   );

endmodule

// File: tb/tb_xcvr_csr_agent.sv
// tb_xcvr_csr_agent: directed self-checking bench for xcvr_csr_agent (LAT=2, MAX_PENDING=2,
// register 5 read-only). Honours XCVR_CSR_AGENT_WRRESP_EN when defined.
module tb_xcvr_csr_agent;

   localparam int DW  = 32;
   localparam int AW  = 13;
   localparam int NR  = 16;
   localparam int LAT = 2;
   localparam int MP  = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [AW-1:0]     s_address;
   logic              s_read;
   logic              s_write;
   logic [DW-1:0]     s_writedata;
   logic [DW/8-1:0]   s_byteenable;
   logic              s_waitrequest;
   logic [DW-1:0]     s_readdata;
   logic              s_readdatavalid;
`ifdef XCVR_CSR_AGENT_WRRESP_EN
   logic [1:0]        s_response;
   logic              s_writeresponsevalid;
`endif
   logic [NR*DW-1:0]  ctl_out;
   logic [NR*DW-1:0]  sts_in;

   int                n_checks;
   int                n_errors;

   always #5 clk = ~clk;

   xcvr_csr_agent #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .NUM_REGS     (NR),
      .RO_MASK      (16'h0020),
      .READ_LATENCY (LAT),
      .MAX_PENDING  (MP)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .s_address            (s_address),
      .s_read               (s_read),
      .s_write              (s_write),
      .s_writedata          (s_writedata),
      .s_byteenable         (s_byteenable),
      .s_waitrequest        (s_waitrequest),
      .s_readdata           (s_readdata),
      .s_readdatavalid      (s_readdatavalid),
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      .s_response           (s_response),
      .s_writeresponsevalid (s_writeresponsevalid),
`endif
      .ctl_out              (ctl_out),
      .sts_in               (sts_in)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctl(input int i);
      return ctl_out[i*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      s_write = 1'b1;
      s_address = a;
      s_writedata = d;
      s_byteenable = be;
      for (int k = 0; k < 20 && s_waitrequest; k++) tick();
      tick();
      s_write = 1'b0;
      s_byteenable = '0;
   endtask

   task automatic read_word(input logic [AW-1:0] a, output logic [31:0] d, output int lat);
      s_read = 1'b1;
      s_address = a;
      for (int k = 0; k < 20 && s_waitrequest; k++) tick();
      tick();
      s_read = 1'b0;
      lat = 1;
      while (!s_readdatavalid && lat < 20) begin
         tick();
         lat++;
      end
      d = s_readdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      int          lat;
      int          nxt;
      int          got;
      int          nv;
      logic        acc;
      logic [9:0]  wh;
      logic [9:0]  vh;
      logic [31:0] exp3 [4];

      n_checks = 0;
      n_errors = 0;
      s_address = '0;
      s_read = 1'b0;
      s_write = 1'b0;
      s_writedata = '0;
      s_byteenable = '0;
      for (int i = 0; i < NR; i++) sts_in[i*DW +: DW] = 32'hBADC_0000 | 32'(i);
      sts_in[5*DW +: DW] = 32'h1234_5678;

      // 1: reset state and release
      repeat (3) @(posedge clk);
      #1;
      check("rst_wait", 32'(s_waitrequest), 1);
      check("rst_rdv", 32'(s_readdatavalid), 0);
      check("rst_rdata", s_readdata, 0);
      check("rst_ctl_any", 32'(|ctl_out), 0);
      reset_n = 1'b1;
      check("rel_wait_first_edge", 32'(s_waitrequest), 1);
      tick();
      check("rel_wait_after_edge", 32'(s_waitrequest), 0);
      check("rel_rdv", 32'(s_readdatavalid), 0);

      // 2: partial write, read next cycle, latency and hold
      do_write(3, 32'hA5A5_A5A5, 4'b0101);
      check("t2_ctl3", ctl(3), 32'h00A5_00A5);
      s_read = 1'b1;
      s_address = 3;
      check("t2_wait", 32'(s_waitrequest), 0);
      tick();
      s_read = 1'b0;
      check("t2_rdv_early", 32'(s_readdatavalid), 0);
      tick();
      check("t2_rdv", 32'(s_readdatavalid), 1);
      check("t2_rdata", s_readdata, 32'h00A5_00A5);
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      check("t2_resp", 32'(s_response), 32'(2'b00));
`endif
      tick();
      check("t2_rdv_pulse", 32'(s_readdatavalid), 0);
      check("t2_hold", s_readdata, 32'h00A5_00A5);
      do_write(3, 32'h1122_3344, 4'b1010);
      check("t2_ctl3_merge", ctl(3), 32'h11A5_33A5);

      // 3: back-to-back reads with backpressure
      do_write(0, 32'h1111_1111, 4'hF);
      do_write(1, 32'h2222_2222, 4'hF);
      do_write(2, 32'h3333_3333, 4'hF);
      repeat (4) tick();
      exp3[0] = 32'h1111_1111;
      exp3[1] = 32'h2222_2222;
      exp3[2] = 32'h3333_3333;
      exp3[3] = 32'h11A5_33A5;
      nxt = 0;
      got = 0;
      wh = '0;
      vh = '0;
      for (int c = 0; c < 10; c++) begin
         wh[c] = s_waitrequest;
         vh[c] = s_readdatavalid;
         if (s_readdatavalid) begin
            if (got < 4) check($sformatf("t3_data%0d", got), s_readdata, exp3[got]);
            got++;
         end
         acc = (nxt < 4) && !s_waitrequest;
         s_read = (nxt < 4);
         s_address = AW'(nxt);
         tick();
         if (acc) nxt++;
      end
      s_read = 1'b0;
      check("t3_accepted", 32'(nxt), 4);
      check("t3_valids", 32'(got), 4);
      check("t3_wait_pattern", 32'(wh), 32'h024);
      check("t3_valid_pattern", 32'(vh), 32'h06C);

      // 4: read-only register
      do_write(5, 32'h0000_0000, 4'hF);
      do_write(5, 32'hFFFF_FFFF, 4'hF);
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      tick();
      check("t4_wrv", 32'(s_writeresponsevalid), 1);
      check("t4_wr_resp", 32'(s_response), 32'(2'b11));
`endif
      check("t4_ctl5", ctl(5), 0);
      read_word(5, d, lat);
      check("t4_rdata", d, 32'h1234_5678);
      check("t4_lat", 32'(lat), 2);
      read_word(3, d, lat);
      check("t4_rw_not_sts", d, 32'h11A5_33A5);

      // 5: address decode boundaries
      read_word(100, d, lat);
      check("t5_decerr_data", d, 32'hDEAD_C0DE);
      check("t5_lat", 32'(lat), 2);
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      check("t5_rd_resp", 32'(s_response), 32'(2'b11));
`endif
      read_word(16, d, lat);
      check("t5_first_oor", d, 32'hDEAD_C0DE);
      read_word(15, d, lat);
      check("t5_last_reg", d, 0);
      do_write(100, 32'hFFFF_FFFF, 4'hF);
`ifdef XCVR_CSR_AGENT_WRRESP_EN
      tick();
      check("t5_wrv", 32'(s_writeresponsevalid), 1);
      check("t5_wr_resp", 32'(s_response), 32'(2'b11));
`endif
      check("t5_no_alias_ctl4", ctl(4), 0);
      check("t5_ctl3_intact", ctl(3), 32'h11A5_33A5);

      // read and write together: write wins, no read response
      repeat (3) tick();
      s_read = 1'b1;
      s_write = 1'b1;
      s_address = 1;
      s_writedata = 32'h5A5A_5A5A;
      s_byteenable = 4'hF;
      check("rw_wait", 32'(s_waitrequest), 0);
      tick();
      s_read = 1'b0;
      s_write = 1'b0;
      s_byteenable = '0;
      nv = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (s_readdatavalid) nv++;
      end
      check("rw_no_rdv", 32'(nv), 0);
      check("rw_ctl1", ctl(1), 32'h5A5A_5A5A);

      // 6: reset with two reads in flight
      s_read = 1'b1;
      s_address = 0;
      tick();
      s_address = 2;
      tick();
      s_read = 1'b0;
      check("t6_full", 32'(s_waitrequest), 1);
      #2;
      reset_n = 1'b0;
      tick();
      check("t6_rst_rdv", 32'(s_readdatavalid), 0);
      check("t6_rst_rdata", s_readdata, 0);
      check("t6_rst_ctl_any", 32'(|ctl_out), 0);
      tick();
      reset_n = 1'b1;
      check("t6_rel_wait", 32'(s_waitrequest), 1);
      tick();
      check("t6_pending_clear", 32'(s_waitrequest), 0);
      nv = 32'(s_readdatavalid);
      for (int c = 0; c < 5; c++) begin
         tick();
         if (s_readdatavalid) nv++;
      end
      check("t6_no_rdv", 32'(nv), 0);
      read_word(1, d, lat);
      check("t6_read_after", d, 0);
      check("t6_lat_after", 32'(lat), 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
